// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dds_sweep_ctrl
//  Purpose  : Linear frequency-sweep controller that feeds the DDS sample strobe
//             and the 32-bit phase increment.
//  Revision : 1.0  initial release
// ============================================================================
module dds_sweep_ctrl #(
    parameter int CLKDIV = 10,
    parameter int DWELL  = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        mode,
    input  logic [31:0] fstart,
    input  logic [31:0] fstop,
    input  logic [31:0] fstep,
    output logic        enableclk,
    output logic [31:0] phaseinc,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int c_div_w   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int c_dwell_w = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_div_w-1:0]   c_div_last   = c_div_w'(CLKDIV - 1);
    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_div_w-1:0]   divcnt_q, divcnt_d;
    logic [c_dwell_w-1:0] dwell_q, dwell_d;
    logic                 enableclk_q, enableclk_d;
    logic [31:0]          phaseinc_q, phaseinc_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [31:0]          fstart_q, fstart_d;
    logic [31:0]          fstop_q, fstop_d;
    logic [31:0]          fstep_q, fstep_d;
    logic                 mode_q, mode_d;

    logic [32:0]          w_sum;
    logic                 w_cfg_ok;
    logic                 w_dwell_last;
    logic                 w_tick;

    // Free-running strobe; it keeps going in IDLE so the DDS never stalls.
    always_comb begin
        divcnt_d    = (divcnt_q == c_div_last) ? '0 : divcnt_q + c_div_w'(1);
        enableclk_d = (divcnt_q == c_div_last);
    end

    // A step update lands on the edge that closes the strobe cycle.
    assign w_tick       = enableclk_q;
    assign w_dwell_last = (dwell_q == c_dwell_last);
    assign w_cfg_ok     = (fstep != 32'd0) && (fstart <= fstop);
    // 33-bit add so a step past 2^32 saturates at fstop instead of wrapping.
    assign w_sum        = {1'b0, phaseinc_q} + {1'b0, fstep_q};

    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        phaseinc_d = phaseinc_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        fstart_d   = fstart_q;
        fstop_d    = fstop_q;
        fstep_d    = fstep_q;
        mode_d     = mode_q;

        if (abort) begin
            state_d = ST_IDLE;
            dwell_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            fstart_d   = fstart;
                            fstop_d    = fstop;
                            fstep_d    = fstep;
                            mode_d     = mode;
                            phaseinc_d = fstart;
                            dwell_d    = '0;
                            state_d    = ST_SWEEP;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_SWEEP: begin
                    if (w_tick) begin
                        if (w_dwell_last) begin
                            dwell_d = '0;
                            if (w_sum >= {1'b0, fstop_q}) begin
                                phaseinc_d = fstop_q;
                                state_d    = ST_HOLD;
                            end else begin
                                phaseinc_d = w_sum[31:0];
                            end
                        end else begin
                            dwell_d = dwell_q + c_dwell_w'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        if (w_dwell_last) begin
                            dwell_d = '0;
                            done_d  = 1'b1;
                            if (mode_q) begin
                                phaseinc_d = fstart_q;
                                state_d    = ST_SWEEP;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            dwell_d = dwell_q + c_dwell_w'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    dwell_d = '0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            divcnt_q    <= '0;
            dwell_q     <= '0;
            enableclk_q <= 1'b0;
            phaseinc_q  <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            fstart_q    <= 32'd0;
            fstop_q     <= 32'd0;
            fstep_q     <= 32'd0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            divcnt_q    <= divcnt_d;
            dwell_q     <= dwell_d;
            enableclk_q <= enableclk_d;
            phaseinc_q  <= phaseinc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            fstart_q    <= fstart_d;
            fstop_q     <= fstop_d;
            fstep_q     <= fstep_d;
            mode_q      <= mode_d;
        end
    end

    assign enableclk = enableclk_q;
    assign phaseinc  = phaseinc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dds_sweep_ctrl
//  Purpose  : Directed self-checking bench for dds_sweep_ctrl (CLKDIV=4, DWELL=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dds_sweep_ctrl;

    localparam int CLKDIV = 4;
    localparam int DWELL  = 2;

    logic        clock = 1'b0;
    logic        reset, start, abort, mode;
    logic [31:0] fstart, fstop, fstep;
    logic        enableclk, busy, done, err;
    logic [31:0] phaseinc;

    dds_sweep_ctrl #(.CLKDIV(CLKDIV), .DWELL(DWELL)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .fstart    (fstart),
        .fstop     (fstop),
        .fstep     (fstep),
        .enableclk (enableclk),
        .phaseinc  (phaseinc),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0]      fstart;
        logic [31:0]      fstop;
        logic [31:0]      fstep;
        logic             exp_err;
        int               nvals;
        logic [3:0][31:0] vals;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] model_pi;
    logic [31:0] samp[8];
    int          nsamp, ndone, nerr, cnt;
    logic        finished, got, done_at_end;

    initial begin
        vecs[0] = '{32'd100, 32'd130, 32'd10, 1'b0, 4,
                    {32'd130, 32'd120, 32'd110, 32'd100}};
        vecs[1] = '{32'd0, 32'd25, 32'd10, 1'b0, 4,
                    {32'd25, 32'd20, 32'd10, 32'd0}};
        vecs[2] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1'b0, 2,
                    {32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0}};
        vecs[3] = '{32'd5, 32'd10, 32'd0, 1'b1, 0, 128'd0};
        vecs[4] = '{32'd50, 32'd40, 32'd1, 1'b1, 0, 128'd0};
        vecs[5] = '{32'd70, 32'd70, 32'd5, 1'b0, 2,
                    {32'd0, 32'd0, 32'd70, 32'd70}};

        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
        fstart = '0; fstop = '0; fstep = '0;
        repeat (3) @(negedge clock);
        check("rst_phaseinc", phaseinc, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_enableclk", {31'd0, enableclk}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        model_pi = 32'd0;

        // ---------------- table-driven single sweeps and rejections ----------
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            start = 1'b1; mode = 1'b0;
            fstart = vecs[i].fstart; fstop = vecs[i].fstop; fstep = vecs[i].fstep;
            @(negedge clock);
            start = 1'b0;
            // scramble inputs: the latched config must be unaffected
            fstart = 32'h5; fstop = 32'h1; fstep = 32'h0; mode = 1'b1;
            if (vecs[i].exp_err) begin
                check($sformatf("v%0d_err", i), {31'd0, err}, 32'd1);
                check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
                check($sformatf("v%0d_pi_kept", i), phaseinc, model_pi);
                @(negedge clock);
                check($sformatf("v%0d_err_pulse", i), {31'd0, err}, 32'd0);
            end else begin
                check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
                check($sformatf("v%0d_first_pi", i), phaseinc, vecs[i].fstart);
                nsamp = 0; ndone = 0; nerr = 0; finished = 1'b0; done_at_end = 1'b0;
                for (int c = 0; c < 200 && !finished; c++) begin
                    if (c > 0) @(negedge clock);
                    if (busy && enableclk) begin
                        if (nsamp < 8) samp[nsamp] = phaseinc;
                        nsamp++;
                    end
                    if (done) ndone++;
                    if (err) nerr++;
                    if (!busy) begin
                        finished = 1'b1;
                        done_at_end = done;
                    end
                    start = (c == 10);
                end
                start = 1'b0;
                check($sformatf("v%0d_timeout", i), {31'd0, finished}, 32'd1);
                check($sformatf("v%0d_nsamp", i), nsamp, 2 * vecs[i].nvals);
                for (int j = 0; j < 2 * vecs[i].nvals && j < nsamp && j < 8; j++)
                    check($sformatf("v%0d_samp%0d", i, j), samp[j], vecs[i].vals[j / 2]);
                check($sformatf("v%0d_done_cnt", i), ndone, 1);
                check($sformatf("v%0d_done_with_busy_fall", i), {31'd0, done_at_end}, 32'd1);
                check($sformatf("v%0d_no_err", i), nerr, 0);
                check($sformatf("v%0d_final_pi", i), phaseinc, vecs[i].fstop);
                model_pi = vecs[i].fstop;
            end
        end

        // ---------------- start together with abort in IDLE -----------------
        @(negedge clock);
        start = 1'b1; abort = 1'b1; fstart = 32'd1; fstop = 32'd2; fstep = 32'd0;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        check("abort_start_no_err", {31'd0, err}, 32'd0);
        check("abort_start_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; abort = 1'b1; fstep = 32'd1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        check("abort_start_valid_busy", {31'd0, busy}, 32'd0);
        check("abort_start_pi", phaseinc, model_pi);

        // ---------------- continuous mode, then abort at 120 ----------------
        @(negedge clock);
        start = 1'b1; mode = 1'b1; fstart = 32'd100; fstop = 32'd130; fstep = 32'd10;
        @(negedge clock);
        start = 1'b0; mode = 1'b0;
        nsamp = 0; got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            if (c > 0) @(negedge clock);
            if (busy && enableclk) begin
                if (nsamp < 8) samp[nsamp] = phaseinc;
                nsamp++;
            end
            if (done) begin
                got = 1'b1;
                check("cont_restart_pi", phaseinc, 32'd100);
                check("cont_busy_at_done", {31'd0, busy}, 32'd1);
            end
        end
        check("cont_done_seen", {31'd0, got}, 32'd1);
        check("cont_nsamp", nsamp, 8);
        check("cont_samp7", samp[7], 32'd130);
        got = 1'b0; ndone = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clock);
            if (done) ndone++;
            if (phaseinc == 32'd120) begin
                got = 1'b1;
                abort = 1'b1;
            end
        end
        check("cont_reach_120", {31'd0, got}, 32'd1);
        check("cont_no_early_done", ndone, 0);
        @(negedge clock);
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_pi_kept", phaseinc, 32'd120);
        check("abort_no_done", {31'd0, done}, 32'd0);
        ndone = 0; cnt = 0;
        repeat (30) begin
            @(negedge clock);
            if (done) ndone++;
            if (busy) cnt++;
        end
        check("abort_quiet_done", ndone, 0);
        check("abort_quiet_busy", cnt, 0);

        // ---------------- reset mid-sweep -----------------------------------
        @(negedge clock);
        start = 1'b1; mode = 1'b0; fstart = 32'd100; fstop = 32'd130; fstep = 32'd10;
        @(negedge clock);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clock);
            if (phaseinc == 32'd110) begin
                got = 1'b1;
                reset = 1'b1;
            end
        end
        check("rst_reach_110", {31'd0, got}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        check("rst_mid_pi", phaseinc, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_enableclk", {31'd0, enableclk}, 32'd0);
        cnt = 0; got = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clock);
            if (enableclk) begin
                got = 1'b1;
                cnt = c;
            end
        end
        check("rst_first_strobe_delay", cnt, CLKDIV);
        @(negedge clock);
        check("strobe_width", {31'd0, enableclk}, 32'd0);
        cnt = 0; got = 1'b0;
        for (int c = 2; c <= 20 && !got; c++) begin
            @(negedge clock);
            if (enableclk) begin
                got = 1'b1;
                cnt = c;
            end
        end
        check("strobe_period", cnt, CLKDIV);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
